// File: rtl/sfp_array_pkg.sv
// Shared encodings and saturating arithmetic for the sfp_array post-processing block.
// Used by sfp_array and sfp_lane_sat; ReLU is built only when SFP_ARRAY_RELU_EN is defined.
package sfp_array_pkg;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Works on widened operands so any lane width up to 63 bits can share one function.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int bw);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = a + b;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

endpackage

// File: rtl/sfp_lane_sat.sv
// One psum lane: overwrite or signed saturating accumulate, then optional output ReLU.
// The relu port exists only when SFP_ARRAY_RELU_EN is defined.
module sfp_lane_sat
    import sfp_array_pkg::*;
#(
    parameter int BW = 16
) (
    input  logic signed [BW-1:0] acc,
    input  logic signed [BW-1:0] add,
    input  logic                 first,
`ifdef SFP_ARRAY_RELU_EN
    input  logic                 relu,
`endif
    output logic signed [BW-1:0] sum,
    output logic signed [BW-1:0] emit
);

    always_comb begin
        sum = first ? add : BW'(sat_add(64'(acc), 64'(add), BW));
`ifdef SFP_ARRAY_RELU_EN
        // Only the emitted copy is clamped; the stored sum keeps its sign.
        emit = (relu && sum[BW-1]) ? '0 : sum;
`else
        emit = sum;
`endif
    end

endmodule

// File: rtl/sfp_array.sv
// Psum accumulation buffer with saturating lanes, pass-through mode and full drain.
// Define SFP_ARRAY_RELU_EN to build the output ReLU; otherwise the relu input is ignored.
module sfp_array
    import sfp_array_pkg::*;
#(
    parameter  int COL     = 8,
    parameter  int PSUM_BW = 16,
    parameter  int DEPTH   = 16,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mode,
    input  logic                     relu,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [COL*PSUM_BW-1:0]   in_data,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic                     drain_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [COL*PSUM_BW-1:0]   out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     drain_done
);

    state_t                    state;
    logic [ADDR_W-1:0]         cnt;
    logic                      drain_tail;
    logic signed [PSUM_BW-1:0] acc      [DEPTH][COL];
    logic signed [PSUM_BW-1:0] lane_sum [COL];
    logic [COL*PSUM_BW-1:0]    emit_vec;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      out_free;
    logic                      accept;
    logic                      drain_load;
    logic                      load;
    logic                      lane_first;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = !reset && (state == RUN) && out_free;
    assign accept     = in_valid && in_ready;
    assign drain_load = (state == DRAIN) && out_free && !drain_tail;
    assign load       = (accept && in_last) || drain_load;
    assign rd_addr    = (state == DRAIN) ? cnt : in_addr;
    // Pass-through behaves as an overwrite; drain reuses the lane as acc + 0.
    assign lane_first = (state == RUN) && (in_first || mode == MODE_OS);

`ifndef SFP_ARRAY_RELU_EN
    logic relu_unused;
    assign relu_unused = relu;
`endif

    for (genvar i = 0; i < COL; i++) begin : g_lane
        logic signed [PSUM_BW-1:0] lane_add;
        logic signed [PSUM_BW-1:0] lane_emit;

        assign lane_add = (state == DRAIN) ? '0 : $signed(in_data[PSUM_BW*i +: PSUM_BW]);

        sfp_lane_sat #(.BW(PSUM_BW)) u_lane (
            .acc   (acc[rd_addr][i]),
            .add   (lane_add),
            .first (lane_first),
`ifdef SFP_ARRAY_RELU_EN
            .relu  (relu),
`endif
            .sum   (lane_sum[i]),
            .emit  (lane_emit)
        );

        assign emit_vec[PSUM_BW*i +: PSUM_BW] = lane_emit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            cnt        <= '0;
            drain_tail <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            drain_done <= 1'b0;
            for (int a = 0; a < DEPTH; a++)
                for (int i = 0; i < COL; i++)
                    acc[a][i] <= '0;
        end else begin
            drain_done <= 1'b0;

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= emit_vec;
                out_addr  <= rd_addr;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (accept && mode == MODE_WS)
                for (int i = 0; i < COL; i++)
                    acc[in_addr][i] <= lane_sum[i];

            case (state)
                RUN: begin
                    if (drain_req) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_load) begin
                        for (int i = 0; i < COL; i++)
                            acc[cnt][i] <= '0;
                        if (cnt == ADDR_W'(DEPTH - 1)) drain_tail <= 1'b1;
                        else                           cnt <= cnt + 1'b1;
                    end
                    // Tail entry is sitting in the output register; finish when it leaves.
                    if (drain_tail && out_ready) begin
                        drain_tail <= 1'b0;
                        cnt        <= '0;
                        state      <= RUN;
                        drain_done <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_array.sv
// Directed scoreboard bench for sfp_array; expectations follow SFP_ARRAY_RELU_EN if defined.
module tb_sfp_array;

    localparam int COL     = 8;
    localparam int PSUM_BW = 16;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int VW      = COL * PSUM_BW;
`ifdef SFP_ARRAY_RELU_EN
    localparam bit RELU_ON = 1'b1;
`else
    localparam bit RELU_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, mode, relu, in_valid, in_ready, in_first, in_last;
    logic              drain_req, out_valid, out_ready, drain_done;
    logic [VW-1:0]     in_data, out_data;
    logic [ADDR_W-1:0] in_addr, out_addr;

    typedef struct packed {
        logic [VW-1:0]     data;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t sb[$];
    int   model_acc [DEPTH][COL];
    int   vec [COL];
    int   checks   = 0;
    int   passed   = 0;
    int   dd_count = 0;

    always #5 clk = ~clk;

    sfp_array #(.COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .relu(relu),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
        .in_first(in_first), .in_last(in_last), .drain_req(drain_req),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .drain_done(drain_done)
    );

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    function automatic int sat(input int v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int outv(input int v, input bit r);
        return (RELU_ON && r && v < 0) ? 0 : v;
    endfunction

    task automatic clr_vec();
        for (int i = 0; i < COL; i++) vec[i] = 0;
    endtask

    task automatic clr_model();
        for (int a = 0; a < DEPTH; a++)
            for (int i = 0; i < COL; i++) model_acc[a][i] = 0;
    endtask

    task automatic model_beat(input bit m, input bit r, input int a, input bit f, input bit l);
        exp_t e;
        e.addr = a[ADDR_W-1:0];
        e.data = '0;
        for (int i = 0; i < COL; i++) begin
            int nv;
            int t;
            if (m == 1'b0) begin
                nv = f ? vec[i] : sat(model_acc[a][i] + vec[i]);
                model_acc[a][i] = nv;
            end else begin
                nv = vec[i];
            end
            t = outv(nv, r);
            e.data[PSUM_BW*i +: PSUM_BW] = t[PSUM_BW-1:0];
        end
        if (l) sb.push_back(e);
    endtask

    task automatic model_drain(input bit r);
        for (int a = 0; a < DEPTH; a++) begin
            exp_t e;
            e.addr = a[ADDR_W-1:0];
            e.data = '0;
            for (int i = 0; i < COL; i++) begin
                int t;
                t = outv(model_acc[a][i], r);
                e.data[PSUM_BW*i +: PSUM_BW] = t[PSUM_BW-1:0];
                model_acc[a][i] = 0;
            end
            sb.push_back(e);
        end
    endtask

    task automatic set_inputs(input bit m, input bit r, input int a, input bit f, input bit l);
        mode     = m;
        relu     = r;
        in_addr  = a[ADDR_W-1:0];
        in_first = f;
        in_last  = l;
        for (int i = 0; i < COL; i++) begin
            int t;
            t = vec[i];
            in_data[PSUM_BW*i +: PSUM_BW] = t[PSUM_BW-1:0];
        end
        in_valid = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic beat(input bit m, input bit r, input int a, input bit f, input bit l);
        bit ok;
        model_beat(m, r, a, f, l);
        set_inputs(m, r, a, f, l);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", {31'd0, ok}, 1);
        if (ok && l) begin
            chk("out_valid_after_last", out_valid, 1);
            chk("out_addr_after_last", out_addr, a);
        end
    endtask

    task automatic wait_sb_empty();
        for (int c = 0; c < 200 && sb.size() != 0; c++) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_addr", out_addr, e.addr);
            end
        end
        if (drain_done === 1'b1) dd_count++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dd0;
        bit found;

        reset = 1'b1; mode = 1'b0; relu = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        in_last = 1'b0; in_addr = '0; in_data = '0; drain_req = 1'b0; out_ready = 1'b1;
        clr_model();
        clr_vec();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_drain_done", drain_done, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", in_ready, 1);

        // WS accumulate at addr 3: lane0 100+200-50, lane1 -3+7-20
        clr_vec(); vec[0] = 100; vec[1] = -3;  beat(0, 0, 3, 1, 0);
        clr_vec(); vec[0] = 200; vec[1] = 7;   beat(0, 0, 3, 0, 0);
        clr_vec(); vec[0] = -50; vec[1] = -20; beat(0, 0, 3, 0, 1);

        // saturation at both rails, plain sum in lane 2
        clr_vec(); vec[0] = 32767; vec[1] = -32768; vec[2] = 5; beat(0, 0, 5, 1, 0);
        clr_vec(); vec[0] = 10;    vec[1] = -1;     vec[2] = 6; beat(0, 0, 5, 0, 1);

        // ReLU at output only; stored -7 re-accumulates to 3
        clr_vec(); vec[2] = -7; vec[3] = 9; beat(0, 1, 7, 1, 1);
        clr_vec(); vec[2] = 10;             beat(0, 1, 7, 0, 1);

        // OS pass-through, discarded non-last beat, buffer untouched
        clr_vec(); vec[0] = -4;  vec[4] = 123; beat(1, 1, 2, 0, 1);
        clr_vec(); vec[0] = 999;               beat(1, 0, 2, 0, 0);
        clr_vec(); vec[0] = 1;                 beat(0, 0, 2, 0, 1);
        wait_sb_empty();

        // backpressure: output held, input stalled for 5 cycles
        out_ready = 1'b0;
        clr_vec(); vec[0] = 42; beat(0, 0, 1, 1, 1);
        clr_vec(); vec[0] = 43; model_beat(0, 0, 9, 1, 1); set_inputs(0, 0, 9, 1, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_data", out_data, sb[0].data);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("reload_out_valid", out_valid, 1);
        chk("reload_out_addr", out_addr, 9);
        wait_sb_empty();

        // full drain with out_ready toggling
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < COL; i++) vec[i] = k * 2;
            beat(0, 0, k, 1, 0);
        end
        clr_vec();
        model_drain(0);
        dd0 = dd_count;
        drain_req = 1'b1;
        @(posedge clk);
        #1 drain_req = 1'b0;
        chk("drain_in_ready", in_ready, 0);
        for (int c = 0; c < 200 && dd_count == dd0; c++) begin
            @(posedge clk);
            #1 out_ready = ~out_ready;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_done_pulses", dd_count - dd0, 1);
        chk("drain_all_beats", sb.size(), 0);
        chk("run_after_drain", in_ready, 1);
        clr_vec(); vec[0] = 5; beat(0, 0, 4, 0, 1);
        wait_sb_empty();

        // reset in the middle of a drain
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < COL; i++) vec[i] = k + 1;
            beat(0, 0, k, 1, 0);
        end
        clr_vec();
        model_drain(0);
        dd0 = dd_count;
        drain_req = 1'b1;
        @(posedge clk);
        #1 drain_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out_addr === 4'd5) found = 1'b1;
        end
        chk("drain_reached_5", {31'd0, found}, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_drain_done", drain_done, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb.delete();
        clr_model();
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_no_done", dd_count - dd0, 0);
        for (int k = 0; k < DEPTH; k++) beat(0, 0, k, 0, 1);
        wait_sb_empty();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sfp_array.md
SFP_ARRAY -- requirements
Module: sfp_array

Interface
REQ-001 Parameter COL, 8, number of psum lanes.
REQ-002 Parameter PSUM_BW, 16, signed lane width.
REQ-003 Parameter DEPTH, 16, accumulator entries per lane; ADDR_W = clog2(DEPTH).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 mode  in  1  0 = WS (accumulate into buffer), 1 = OS (pass-through, no buffer update).
REQ-007 relu  in  1  apply ReLU to emitted results.
REQ-008 in_valid / in_ready  in / out  1 / 1  input beat handshake.
REQ-009 in_data  in  COL*PSUM_BW  psum vector; lane i at [PSUM_BW*(i+1)-1 : PSUM_BW*i].
REQ-010 in_addr  in  ADDR_W  accumulator entry index.
REQ-011 in_first / in_last  in  1 / 1  overwrite instead of accumulate / emit entry after update.
REQ-012 drain_req  in  1  one-cycle request to emit and clear all entries.
REQ-013 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-014 out_data / out_addr  out  COL*PSUM_BW / ADDR_W  result vector and its entry index.
REQ-015 drain_done  out  1  one-cycle pulse after final drain beat is accepted.

Function
REQ-016 FSM states RUN and DRAIN; reset state RUN.
REQ-017 Beat accepted when in_valid && in_ready; in_ready = (state==RUN) && (!out_valid || out_ready).
REQ-018 WS, accepted beat: acc[in_addr] <= in_first ? in_data : acc[in_addr] + in_data, written at that edge; back-to-back same-address beats need no stall.
REQ-019 Lane addition signed, saturating to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]; lanes independent.
REQ-020 WS with in_last: out_data = updated value (post-saturation, post-ReLU), out_addr = in_addr, out_valid registered 1 cycle after acceptance.
REQ-021 OS: accepted beat never writes acc; in_last emits ReLU'd in_data next cycle; beats without in_last are discarded.
REQ-022 ReLU, when enabled, clamps negative lanes to 0 at output only; stored acc remains signed.
REQ-023 out_valid holds, out_data/out_addr stable, until out_ready; register reloads in the same cycle it empties.
REQ-024 drain_req in RUN: any beat accepted that cycle completes first; DRAIN entered next cycle; drain_req in DRAIN ignored.
REQ-025 DRAIN: counter 0..DEPTH-1 emits acc[cnt] (ReLU applied) with out_addr=cnt, one entry each time output register is free, clears acc[cnt] to 0 on load.
REQ-026 After entry DEPTH-1 accepted at output: drain_done pulses 1 cycle, FSM returns to RUN, counter returns to 0.
REQ-027 mode and relu sampled per beat/entry at load; changes mid-stream affect only later beats.

Reset
REQ-028 Reset clears all acc entries, out_valid=0, out_data=0, out_addr=0, drain_done=0, counter=0, state=RUN; asserting mid-DRAIN abandons drain without drain_done.
REQ-029 in_ready is 0 while reset is asserted.

Configuration
REQ-030 Macro SFP_ARRAY_RELU_EN defined: ReLU path per REQ-022; undefined: relu input ignored, outputs are raw signed values, no ReLU logic synthesised.

Structure
REQ-031 Shared package holds mode encodings (MODE_WS=0, MODE_OS=1), FSM state enum, and a signed saturating-add function.
REQ-032 One sub-module sfp_lane_sat (single-lane saturating add + optional ReLU), instantiated COL times by generate.

Verification
REQ-033 WS, addr 3: beats 100(first), 200, -50(last) lane 0 -> out_data lane0=250, out_addr=3, 1 cycle after last accept.
REQ-034 PSUM_BW=16, 32767 (first) + 10 (last) -> 32767; -32768 + -1 -> -32768.
REQ-035 relu=1, result -7 lane 2, 9 lane 3 -> lanes 0 and 9; re-accumulate same addr, first=0, +10 -> 3 (stored value was -7); SFP_ARRAY_RELU_EN undefined -> -7.
REQ-036 out_ready=0 with pending result -> in_ready=0, out_data stable 5 cycles; out_ready=1 -> next beat accepted that cycle.
REQ-037 Entries 0..15 loaded with k*2, drain_req, out_ready toggling 1/0 -> 16 beats addr 0..15 values k*2, drain_done one pulse, subsequent first=0 beat of 5 yields 5.
REQ-038 Reset asserted mid-DRAIN at cnt=6 -> out_valid=0 immediately, no drain_done, all entries read back 0.
